alu_frame_sequencer: RTL
========================

Name: alu_frame_sequencer

Overview:
- Parametrised successor to the single-byte operand/opcode collector feeding the ALU.
- Assembles multi-byte operands A and B plus one opcode byte from the UART RX byte stream, drives the combinational ALU, and streams the multi-byte result back to UART TX over a valid/ready handshake.
- Adds inter-byte timeout recovery and TX back-pressure. Sits between uart_rx/uart_tx and alu in the top level.

Parameters:
- NB_BYTE, 8, UART byte width.
- NB_DATA, 16, operand/result width; must be a multiple of NB_BYTE and at least NB_BYTE. NBYTES = NB_DATA/NB_BYTE.
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the opcode byte.
- TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of one frame; 0 disables timeout.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_rx_data  in  NB_BYTE  received byte
- o_tx_data  out  NB_BYTE  result byte to transmit
- o_tx_valid  out  1  o_tx_data valid; held until accepted
- i_tx_ready  in  1  TX accepts byte when o_tx_valid && i_tx_ready
- o_busy  out  1  high in EXEC and TX
- o_timeout  out  1  one-cycle pulse on frame abort
- o_err  out  1  one-cycle pulse on illegal opcode (feature only, else tied 0)

Behaviour:
- Reset (async, active-high): state=RX_A, byte index=0, A/B/opcode/result registers=0, timeout counter=0. All outputs 0.
- Byte order: little-endian. The first byte received for an operand fills bits [NB_BYTE-1:0].
- RX_A: each i_rx_valid stores the byte at the current index and increments it. After NBYTES bytes: index=0, go to RX_B.
- RX_B: same as RX_A. After NBYTES bytes go to RX_OP.
- RX_OP: i_rx_valid latches i_rx_data[NB_OP-1:0], go to EXEC.
- EXEC (exactly 1 cycle): result register <= alu output, go to TX.
- Latency: o_tx_valid rises 2 clock edges after the edge that sampled the opcode byte.
- TX: o_tx_valid=1, o_tx_data = result byte[index], LSB byte first.
  - On valid&&ready: index increments.
  - After byte NBYTES-1 is accepted: index=0, o_tx_valid drops the same edge, go to RX_A.
  - o_tx_data must stay stable while valid && !ready.
- i_rx_valid in EXEC/TX is ignored. Bytes are dropped with no error.
- Timeout counter:
  - Counts only in RX states with at least one byte of the current frame already received.
  - Clears on every accepted RX byte.
  - On reaching TIMEOUT_CYCLES: state=RX_A, index=0, o_timeout pulses 1 cycle, A/B/opcode unchanged.
  - If i_rx_valid coincides with expiry, the byte wins, the counter clears, and there is no timeout.
- A/B/opcode registers keep the last frame's values, so the ALU output stays static between frames.
- Reset mid-frame or mid-TX: immediate abort to the reset state, with no partial TX completion.
- Illegal state encodings: recover to RX_A with index=0.

Optional Feature:
- Macro: ALU_FRAME_OPCODE_CHECK_EN.
- Defined:
  - In RX_OP the opcode is checked against the supported list.
  - Illegal opcode: o_err pulses 1 cycle, EXEC is skipped, and TX sends a single byte ERR_BYTE=0xFF instead of NBYTES bytes, then returns to RX_A.
- Undefined: every opcode is passed to the ALU, and o_err is constant 0.

Decomposition:
- Package alu_frame_pkg holds:
  - state localparams, one-hot: RX_A, RX_B, RX_OP, EXEC, TX;
  - opcode constants: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111;
  - ERR_BYTE.
- Sub-modules:
  - Existing alu, instantiated with N_BITS_DATA=NB_DATA, N_BITS_OP=NB_OP.
  - Timeout counter as frame_timeout: enable, clear and expire pulse, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- NB_DATA=16, ready=1: RX 34,12,01,01,20 (ADD) -> TX 35 then 13; o_tx_valid rises 2 edges after the opcode edge; back to RX_A.
- Back-pressure: same frame with i_tx_ready low for 5 cycles -> o_tx_valid held, o_tx_data=35 stable, then 35,13 in order with no loss.
- TIMEOUT_CYCLES=16: RX one byte 0xAA, idle 16 cycles -> o_timeout 1-cycle pulse. Next frame 02,00,03,00,22 (SUB) -> TX FF,FF.
- RX flood during TX: extra bytes 0x55 strobed in EXEC/TX -> ignored. The next frame decodes correctly from its first byte.
- Async reset asserted mid-TX after the first byte -> o_tx_valid=0 immediately, state RX_A. A fresh frame computes correctly.
- With ALU_FRAME_OPCODE_CHECK_EN: opcode 0x3F -> o_err pulse, single TX byte FF. With the macro undefined: o_err stays 0 and NBYTES result bytes are sent.

Source files
------------

// File: rtl/alu_frame_sequencer_pkg.sv
// Shared constants for the ALU frame sequencer: one-hot state encodings,
// supported ALU opcodes, the error reply byte and an opcode legality helper.
package alu_frame_pkg;

    localparam int NB_STATE = 5;

    localparam logic [NB_STATE-1:0] ST_RX_A  = 5'b00001;
    localparam logic [NB_STATE-1:0] ST_RX_B  = 5'b00010;
    localparam logic [NB_STATE-1:0] ST_RX_OP = 5'b00100;
    localparam logic [NB_STATE-1:0] ST_EXEC  = 5'b01000;
    localparam logic [NB_STATE-1:0] ST_TX    = 5'b10000;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    // Single byte sent back instead of a result when the opcode is rejected.
    localparam logic [7:0] ERR_BYTE = 8'hFF;

    // True for every opcode the ALU implements.
    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU. Unsupported opcodes produce zero.
module alu
    import alu_frame_pkg::*;
#(
    parameter int N_BITS_DATA = 8,
    parameter int N_BITS_OP   = 6
) (
    input  logic [N_BITS_DATA-1:0] i_data_a,
    input  logic [N_BITS_DATA-1:0] i_data_b,
    input  logic [N_BITS_OP-1:0]   i_op,
    output logic [N_BITS_DATA-1:0] o_data
);

    logic [5:0] w_op;

    assign w_op = 6'(i_op);

    // Opcode decode; shifts use the whole B operand as the shift amount.
    always_comb begin
        case (w_op)
            OP_ADD:  o_data = i_data_a + i_data_b;
            OP_SUB:  o_data = i_data_a - i_data_b;
            OP_AND:  o_data = i_data_a & i_data_b;
            OP_OR:   o_data = i_data_a | i_data_b;
            OP_XOR:  o_data = i_data_a ^ i_data_b;
            OP_SRA:  o_data = $signed(i_data_a) >>> i_data_b;
            OP_SRL:  o_data = i_data_a >> i_data_b;
            OP_NOR:  o_data = ~(i_data_a | i_data_b);
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/frame_timeout.sv
// Inter-byte idle counter. Counts enabled cycles since the last clear and
// pulses o_expire in the cycle the count would reach TIMEOUT_CYCLES.
// A clear in the same cycle wins over expiry. TIMEOUT_CYCLES=0 disables it.
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expire
);

    localparam int NB_COUNT = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_count
            localparam logic [NB_COUNT-1:0] LAST = NB_COUNT'(TIMEOUT_CYCLES - 1);

            logic [NB_COUNT-1:0] r_count;
            logic                w_hit;

            assign w_hit    = i_enable && !i_clear && (r_count == LAST);
            assign o_expire = w_hit;

            // Idle-cycle count; restarts on any byte, on expiry or when disabled.
            always_ff @(posedge i_clock or posedge i_reset) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // flop samples pre-edge values regardless of statement order.
                if (i_reset) begin
                    r_count <= '0;
                end else if (i_clear || w_hit || !i_enable) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + NB_COUNT'(1);
                end
            end
        end else begin : g_off
            assign o_expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/alu_frame_sequencer.sv
// ALU frame sequencer: collects little-endian operands A and B plus an opcode
// byte from the UART RX stream, runs the ALU for one cycle and streams the
// result LSB byte first over a valid/ready TX handshake. Frames stalled for
// TIMEOUT_CYCLES idle clocks are abandoned.
// Optional build macro ALU_FRAME_OPCODE_CHECK_EN: reject unsupported opcodes
// with an o_err pulse and a single ERR_BYTE reply instead of a result.
module alu_frame_sequencer
    import alu_frame_pkg::*;
#(
    parameter int NB_BYTE        = 8,
    parameter int NB_DATA        = 16,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_valid,
    input  logic [NB_BYTE-1:0] i_rx_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_err
);

    localparam int NBYTES = NB_DATA / NB_BYTE;
    localparam int NB_IDX = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(NBYTES - 1);

    logic [NB_STATE-1:0] r_state;
    logic [NB_STATE-1:0] w_next_state;
    logic [NB_IDX-1:0]   r_index;
    logic [NB_DATA-1:0]  r_data_a;
    logic [NB_DATA-1:0]  r_data_b;
    logic [NB_OP-1:0]    r_op;
    logic [NB_DATA-1:0]  r_result;
    logic                r_tx_valid;
    logic                r_timeout;

    logic [NB_DATA-1:0]  w_alu_result;
    logic                w_rx_state;
    logic                w_rx_accept;
    logic                w_tx_accept;
    logic                w_index_last;
    logic                w_tx_last;
    logic                w_op_legal;
    logic                w_to_enable;
    logic                w_to_expire;

`ifdef ALU_FRAME_OPCODE_CHECK_EN
    logic                r_err;
    logic                r_err_frame;

    assign w_op_legal = is_legal_op(6'(i_rx_data[NB_OP-1:0]));
    assign w_tx_last  = r_err_frame || w_index_last;
`else
    assign w_op_legal = 1'b1;
    assign w_tx_last  = w_index_last;
`endif

    assign w_rx_state   = (r_state == ST_RX_A) || (r_state == ST_RX_B) || (r_state == ST_RX_OP);
    assign w_rx_accept  = i_rx_valid && w_rx_state;
    assign w_tx_accept  = r_tx_valid && i_tx_ready;
    assign w_index_last = (r_index == LAST_IDX);

    // The idle counter only runs once the current frame has started.
    assign w_to_enable  = ((r_state == ST_RX_A) && (r_index != '0)) ||
                          (r_state == ST_RX_B) || (r_state == ST_RX_OP);

    alu #(
        .N_BITS_DATA (NB_DATA),
        .N_BITS_OP   (NB_OP)
    ) u_alu (
        .i_data_a (r_data_a),
        .i_data_b (r_data_b),
        .i_op     (r_op),
        .o_data   (w_alu_result)
    );

    frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (w_to_enable),
        .i_clear  (w_rx_accept),
        .o_expire (w_to_expire)
    );

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RX_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; unknown encodings fall back to RX_A.
    always_comb begin
        // NOTE: default assignment first so no path through the block can
        // leave the signal unassigned and infer a latch.
        w_next_state = r_state;
        if (w_to_expire) begin
            w_next_state = ST_RX_A;
        end else begin
            case (r_state)
                ST_RX_A:  if (i_rx_valid && w_index_last) w_next_state = ST_RX_B;
                ST_RX_B:  if (i_rx_valid && w_index_last) w_next_state = ST_RX_OP;
                ST_RX_OP: if (i_rx_valid) w_next_state = w_op_legal ? ST_EXEC : ST_TX;
                ST_EXEC:  w_next_state = ST_TX;
                ST_TX:    if (w_tx_accept && w_tx_last) w_next_state = ST_RX_A;
                default:  w_next_state = ST_RX_A;
            endcase
        end
    end

    // Datapath: operand capture, result latch, byte index and TX valid.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_index    <= '0;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_tx_valid <= 1'b0;
            r_timeout  <= 1'b0;
`ifdef ALU_FRAME_OPCODE_CHECK_EN
            r_err       <= 1'b0;
            r_err_frame <= 1'b0;
`endif
        end else begin
            r_timeout <= w_to_expire;
`ifdef ALU_FRAME_OPCODE_CHECK_EN
            r_err <= 1'b0;
`endif
            if (w_to_expire) begin
                r_index <= '0;
            end else begin
                case (r_state)
                    ST_RX_A: begin
                        if (i_rx_valid) begin
                            r_data_a[int'(r_index) * NB_BYTE +: NB_BYTE] <= i_rx_data;
                            r_index <= w_index_last ? '0 : r_index + NB_IDX'(1);
                        end
                    end
                    ST_RX_B: begin
                        if (i_rx_valid) begin
                            r_data_b[int'(r_index) * NB_BYTE +: NB_BYTE] <= i_rx_data;
                            r_index <= w_index_last ? '0 : r_index + NB_IDX'(1);
                        end
                    end
                    ST_RX_OP: begin
                        if (i_rx_valid) begin
                            r_op <= i_rx_data[NB_OP-1:0];
`ifdef ALU_FRAME_OPCODE_CHECK_EN
                            r_err       <= !w_op_legal;
                            r_err_frame <= !w_op_legal;
`endif
                        end
                    end
                    ST_EXEC: begin
                        r_result <= w_alu_result;
                    end
                    ST_TX: begin
                        // First TX cycle presents byte 0; later cycles advance on accept.
                        if (!r_tx_valid) begin
                            r_tx_valid <= 1'b1;
                        end else if (w_tx_accept) begin
                            if (w_tx_last) begin
                                r_index    <= '0;
                                r_tx_valid <= 1'b0;
                            end else begin
                                r_index <= r_index + NB_IDX'(1);
                            end
                        end
                    end
                    default: begin
                        r_index    <= '0;
                        r_tx_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output decode from registered state; o_tx_data holds while not accepted.
    always_comb begin
        o_tx_valid = r_tx_valid;
        o_busy     = (r_state == ST_EXEC) || (r_state == ST_TX);
        o_timeout  = r_timeout;
        o_tx_data  = '0;
        if (r_tx_valid) begin
            o_tx_data = r_result[int'(r_index) * NB_BYTE +: NB_BYTE];
        end
`ifdef ALU_FRAME_OPCODE_CHECK_EN
        o_err = r_err;
        if (r_tx_valid && r_err_frame) begin
            o_tx_data = NB_BYTE'(ERR_BYTE);
        end
`else
        o_err = 1'b0;
`endif
    end

endmodule
